// File: rtl/sdram_s1_responder.sv
// Avalon-MM s1 responder on on-chip RAM standing in for the SDRAM controller; SDRAM_RESP_STALL_INJECT_EN adds LFSR stalls.
// Latency: writes land at the accept edge; readdatavalid follows READ_LATENCY cycles after read accept, in order.
// Backpressure: waitrequest is a function of registers only: high in INIT/REFRESH, at MAX_PENDING, or on an injected stall.
module sdram_s1_responder #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 32,
    parameter int MEM_AW         = 10,
    parameter int READ_LATENCY   = 3,
    parameter int MAX_PENDING    = 4,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_STALL  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable_n,
    input  logic                s1_chipselect,
    input  logic [DATA_W-1:0]   s1_writedata,
    input  logic                s1_read_n,
    input  logic                s1_write_n,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    output logic [3:0]          o_pending,
    output logic                o_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(REFRESH_PERIOD) + 1;
    localparam int STL_W = $clog2(REFRESH_STALL) + 1;
    localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REFRESH_PERIOD - 1);
    localparam logic [STL_W-1:0] STALL_LAST = STL_W'(REFRESH_STALL - 1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_REFRESH} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   ref_cnt, ref_cnt_nxt;
    logic [STL_W-1:0]   stall_cnt, stall_cnt_nxt;
    logic               stall_inj;

    logic [DATA_W-1:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0]       mem_addr;
    logic                    unused_addr_hi;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [DATA_W-1:0]       dat_pipe [READ_LATENCY];

    logic acc, rd_acc, wr_acc, both_acc;

    assign mem_addr       = s1_address[MEM_AW-1:0];
    assign unused_addr_hi = ^s1_address[ADDR_W-1:MEM_AW];

`ifdef SDRAM_RESP_STALL_INJECT_EN
    logic [15:0] lfsr;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
    assign stall_inj = (lfsr[1:0] == 2'b00);
`else
    assign stall_inj = 1'b0;
`endif

    assign s1_waitrequest = (state != ST_RUN) | (o_pending == 4'(MAX_PENDING)) | stall_inj;

    assign acc      = s1_chipselect & ~s1_waitrequest & (~s1_read_n | ~s1_write_n);
    assign wr_acc   = acc & ~s1_write_n;
    assign rd_acc   = acc & ~s1_read_n & s1_write_n;
    assign both_acc = acc & ~s1_read_n & ~s1_write_n;

    // Refresh counter free-runs in every state so stall starts stay REFRESH_PERIOD apart.
    always_comb begin
        state_nxt     = state;
        ref_cnt_nxt   = ref_cnt + 1'b1;
        stall_cnt_nxt = '0;
        case (state)
            ST_INIT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (ref_cnt == REF_LAST) begin
                    state_nxt   = ST_REFRESH;
                    ref_cnt_nxt = '0;
                end
            end
            ST_REFRESH: begin
                stall_cnt_nxt = stall_cnt + 1'b1;
                if (stall_cnt == STALL_LAST) begin
                    state_nxt     = ST_RUN;
                    stall_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_INIT;
            ref_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ref_cnt   <= ref_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            for (int b = 0; b < BE_W; b++) begin
                if (!s1_byteenable_n[b]) begin
                    mem[mem_addr][b*8 +: 8] <= s1_writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read word is captured at the accept edge, so a same-edge write never leaks into it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_acc;
            dat_pipe[0] <= rd_acc ? mem[mem_addr] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign s1_readdatavalid = vld_pipe[READ_LATENCY-1];
    assign s1_readdata      = dat_pipe[READ_LATENCY-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pending <= '0;
            o_err     <= 1'b0;
        end else begin
            if (rd_acc && !s1_readdatavalid) begin
                o_pending <= o_pending + 4'd1;
            end else if (!rd_acc && s1_readdatavalid) begin
                o_pending <= o_pending - 4'd1;
            end
            if (both_acc) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sdram_s1_responder.md
Name: sdram_s1_responder

Overview:
Avalon-MM pipelined slave that is the responder end of the SDRAM controller s1 port. It is backed by on-chip memory and has a fixed read latency, a bounded number of outstanding reads, and periodic refresh stalls. It stands in for the SDRAM controller in simulation and on-chip test builds, so the 16-bit SDRAM access masters can be exercised against real waitrequest/readdatavalid timing.

Parameters:
ADDR_W, 23, width of s1_address
DATA_W, 32, width of s1_readdata and s1_writedata; must be a multiple of 8
MEM_AW, 10, log2 of memory depth in words; only s1_address[MEM_AW-1:0] is decoded
READ_LATENCY, 3, cycles from read accept to s1_readdatavalid; legal range 1..8
MAX_PENDING, 4, maximum outstanding reads; legal range 1..15
REFRESH_PERIOD, 64, cycles between refresh stall starts; must be greater than REFRESH_STALL
REFRESH_STALL, 4, cycles of forced waitrequest per refresh

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-high
s1_address  in  ADDR_W  word address
s1_byteenable_n  in  DATA_W/8  active-low byte lanes, write only
s1_chipselect  in  1  slave select
s1_writedata  in  DATA_W  write data
s1_read_n  in  1  active-low read request
s1_write_n  in  1  active-low write request
s1_readdata  out  DATA_W  read data, valid only with s1_readdatavalid
s1_readdatavalid  out  1  one-cycle read response strobe
s1_waitrequest  out  1  stall; command is not accepted while high
o_pending  out  4  outstanding read count
o_err  out  1  sticky protocol error flag

Behaviour:
- Reset values: s1_readdata=0, s1_readdatavalid=0, s1_waitrequest=1, o_pending=0, o_err=0, refresh counter=0, state=INIT. Memory contents are not reset.
- Reset mid-operation flushes the latency pipeline and the pending count. No readdatavalid is produced for reads accepted before reset.
- s1_waitrequest is driven from registers only; there is no combinational path from inputs.
- s1_waitrequest = (state!=RUN) | (o_pending==MAX_PENDING) | stall-injection term (see Optional Feature).
- State machine:
  - INIT: one cycle after reset release, then RUN.
  - RUN: accepts commands. When the refresh counter reaches REFRESH_PERIOD-1, go to REFRESH.
  - REFRESH: lasts REFRESH_STALL cycles, then RUN. The refresh counter wraps to 0 on REFRESH entry.
- Accept condition: s1_chipselect & ~s1_waitrequest & (~s1_read_n | ~s1_write_n).
- Read and write both asserted in an accepted cycle: the write executes, the read is dropped, o_err is set until reset.
- Write: takes effect at the accept edge, only on byte lanes whose s1_byteenable_n bit is 0. No response. All-ones byteenable_n is a legal no-op.
- Read: the memory word is sampled at the accept edge.
  - Write-first ordering: a write accepted on an earlier edge is visible to the read.
  - s1_readdatavalid pulses exactly READ_LATENCY cycles after the accept edge, carrying that word. Responses return in order.
  - One read per cycle is sustained while o_pending < MAX_PENDING.
- o_pending: +1 on read accept, -1 on readdatavalid, unchanged when both occur in the same cycle. It never exceeds MAX_PENDING.
- Outstanding reads keep completing during REFRESH and while waitrequest is high.
- Address wrap: upper address bits are ignored, so address A aliases A + 2^MEM_AW.
- s1_chipselect=0: all requests are ignored and o_err is unaffected.

Optional Feature:
SDRAM_RESP_STALL_INJECT_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) resets to 16'hACE1 and advances every cycle. When lfsr[1:0]==2'b00, waitrequest is ORed high for that cycle. This injects pseudo-random stalls that masters must tolerate. Read latency after accept is unchanged.
- Undefined: no LFSR; waitrequest comes only from state and o_pending.

Test Plan:
- Reset release -> waitrequest=1 for the INIT cycle, then 0. readdatavalid=0 and o_pending=0 throughout.
- Write 0x12345678 to addr 5 with byteenable_n=0000, then read addr 5 on the next cycle -> readdatavalid exactly 3 cycles after the read accept, readdata=0x12345678.
- Write 0xAABBCCDD with byteenable_n=1100 over 0x12345678, then read -> 0x1234CCDD.
- Back-to-back reads of addrs 0..7 holding distinct data, MAX_PENDING=2, READ_LATENCY=3 -> waitrequest rises when o_pending=2. All 8 responses arrive in order with correct data; o_pending never exceeds 2.
- Free-run across cycle 63 -> waitrequest high for 4 cycles and no command accepted. A read accepted at cycle 62 still returns valid at cycle 65.
- read_n=0 and write_n=0 together on addr 9 with data 0x0F0F0F0F -> memory[9]=0x0F0F0F0F, no readdatavalid, o_err=1. Assert i_rst with 2 reads pending -> o_pending=0, o_err=0, no stale readdatavalid after release.
